// File: rtl/spy_draw_pkg.sv
// Shared types and constants for the cell drawing path.
// Contents: FSM state enum, default cell geometry, screen bounds,
// colour constants and the packed draw request carried between stages.
package spy_draw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CELL_W_DEF  = 8;
  localparam int unsigned CELL_H_DEF  = 7;
  localparam int unsigned COORD_W_DEF = 8;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [2:0] COL_RED   = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BLACK = 3'b000;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
    logic [2:0]             colour;
    logic                   full;
  } draw_req_t;

endpackage

// File: rtl/cell_plotter_if.sv
// Request/pixel bus between the grid stage, the cell plotter and the VGA adapter.
// master: drives start, x_in, y_in, colour_in, draw_full; observes status and pixels.
// slave : the plotter; drives ready, vga_x, vga_y, vga_colour, plot, busy, done, overflow.
interface cell_plotter_if #(
  parameter int unsigned COORD_W = 8
) ();

  logic               start;
  logic [COORD_W-1:0] x_in;
  logic [COORD_W-1:0] y_in;
  logic [2:0]         colour_in;
  logic               draw_full;

  logic               ready;
  logic [COORD_W-1:0] vga_x;
  logic [COORD_W-1:0] vga_y;
  logic [2:0]         vga_colour;
  logic               plot;
  logic               busy;
  logic               done;
  logic               overflow;

  modport master (
    output start, x_in, y_in, colour_in, draw_full,
    input  ready, vga_x, vga_y, vga_colour, plot, busy, done, overflow
  );

  modport slave (
    input  start, x_in, y_in, colour_in, draw_full,
    output ready, vga_x, vga_y, vga_colour, plot, busy, done, overflow
  );

endinterface

// File: rtl/draw_req_buf.sv
// One-entry pending request buffer with sticky overflow.
// Ports: clk, reset (async, active-low), i_wr/i_wr_req write side,
// i_rd consume strobe, o_rd_req/o_valid held entry, o_overflow sticky drop flag.
module draw_req_buf
  import spy_draw_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_wr,
  input  draw_req_t i_wr_req,
  input  logic      i_rd,
  output draw_req_t o_rd_req,
  output logic      o_valid,
  output logic      o_overflow
);

  draw_req_t r_req;
  logic      r_valid;
  logic      r_overflow;

  // A write lands if the slot is empty or being drained this same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_req      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (i_wr) begin
      if (!r_valid || i_rd) begin
        r_req   <= i_wr_req;
        r_valid <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (i_rd) begin
      r_valid <= 1'b0;
    end
  end

  assign o_rd_req   = r_req;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/cell_plotter.sv
// Rasterises one cell request (top-left X/Y, colour, full/outline) into
// single-pixel plot commands for the 160x120 VGA adapter, one pixel per cycle.
// Ports: clk, reset (async, active-low), bus (cell_plotter_if.slave) carrying
// start/x_in/y_in/colour_in/draw_full in and ready/vga_*/plot/busy/done/overflow out.
// Optional: define CELL_PLOTTER_CLIP_EN to suppress plots outside the screen
// or whose coordinate sum carried out of COORD_W.
module cell_plotter
  import spy_draw_pkg::*;
#(
  parameter int unsigned CELL_W  = CELL_W_DEF,
  parameter int unsigned CELL_H  = CELL_H_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  cell_plotter_if.slave bus
);

  localparam int unsigned CX_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned CY_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  state_t             r_state;
  logic [CX_W-1:0]    r_cx;
  logic [CY_W-1:0]    r_cy;
  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_y0;
  logic [2:0]         r_colour;
  logic               r_full;

  logic [COORD_W-1:0] r_vga_x;
  logic [COORD_W-1:0] r_vga_y;
  logic [2:0]         r_vga_colour;
  logic               r_plot;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;

  draw_req_t          w_in_req;
  draw_req_t          w_buf_req;
  draw_req_t          w_next_req;
  logic               w_buf_valid;
  logic               w_buf_wr;
  logic               w_buf_rd;
  logic               w_buf_ovf;
  logic               w_load;
  logic               w_last_x;
  logic               w_last_y;
  logic               w_border;
  logic               w_visible;
  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;

  assign w_in_req.x      = COORD_W_DEF'(bus.x_in);
  assign w_in_req.y      = COORD_W_DEF'(bus.y_in);
  assign w_in_req.colour = bus.colour_in;
  assign w_in_req.full   = bus.draw_full;

  // Starts during a draw, or during DONE while the held entry is drained, go to the buffer.
  assign w_buf_wr = bus.start &&
                    ((r_state == DRAW) || ((r_state == DONE) && w_buf_valid));
  assign w_buf_rd = (r_state == DONE) && w_buf_valid;

  draw_req_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .i_wr       (w_buf_wr),
    .i_wr_req   (w_in_req),
    .i_rd       (w_buf_rd),
    .o_rd_req   (w_buf_req),
    .o_valid    (w_buf_valid),
    .o_overflow (w_buf_ovf)
  );

  // The held entry has priority over a same-cycle start when a cell completes.
  assign w_next_req = w_buf_rd ? w_buf_req : w_in_req;
  assign w_load     = ((r_state == IDLE) && bus.start) ||
                      ((r_state == DONE) && (w_buf_valid || bus.start));

  assign w_last_x = (r_cx == CX_W'(CELL_W - 1));
  assign w_last_y = (r_cy == CY_W'(CELL_H - 1));
  assign w_border = (r_cx == '0) || w_last_x || (r_cy == '0) || w_last_y;

`ifdef CELL_PLOTTER_CLIP_EN
  logic [COORD_W:0] w_sum_x;
  logic [COORD_W:0] w_sum_y;

  // The extra sum bit catches carry-out, which is always beyond the screen.
  assign w_sum_x   = {1'b0, r_x0} + (COORD_W+1)'(r_cx);
  assign w_sum_y   = {1'b0, r_y0} + (COORD_W+1)'(r_cy);
  assign w_px      = w_sum_x[COORD_W-1:0];
  assign w_py      = w_sum_y[COORD_W-1:0];
  assign w_visible = (w_sum_x < (COORD_W+1)'(SCREEN_W)) &&
                     (w_sum_y < (COORD_W+1)'(SCREEN_H));
`else
  assign w_px      = r_x0 + COORD_W'(r_cx);
  assign w_py      = r_y0 + COORD_W'(r_cy);
  assign w_visible = 1'b1;
`endif

  // Control FSM, raster counters and registered pixel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cx         <= '0;
      r_cy         <= '0;
      r_x0         <= '0;
      r_y0         <= '0;
      r_colour     <= '0;
      r_full       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_plot <= 1'b0;
      r_done <= 1'b0;

      if (w_load) begin
        r_x0     <= COORD_W'(w_next_req.x);
        r_y0     <= COORD_W'(w_next_req.y);
        r_colour <= w_next_req.colour;
        r_full   <= w_next_req.full;
        r_cx     <= '0;
        r_cy     <= '0;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= DRAW;
            r_busy  <= 1'b1;
            r_ready <= 1'b0;
          end
        end

        DRAW: begin
          r_vga_x      <= w_px;
          r_vga_y      <= w_py;
          r_vga_colour <= r_colour;
          r_plot       <= (r_full || w_border) && w_visible;
          if (w_last_x) begin
            r_cx <= '0;
            if (w_last_y) begin
              r_state <= DONE;
            end else begin
              r_cy <= r_cy + CY_W'(1);
            end
          end else begin
            r_cx <= r_cx + CX_W'(1);
          end
        end

        DONE: begin
          r_done <= 1'b1;
          if (w_load) begin
            r_state <= DRAW;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.vga_x      = r_vga_x;
  assign bus.vga_y      = r_vga_y;
  assign bus.vga_colour = r_vga_colour;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.overflow   = w_buf_ovf;

endmodule

// File: tb/tb_cell_plotter.sv
// Scoreboard bench for cell_plotter: stimulus pushes the expected plotted
// pixels and done marker per cell; a negedge monitor pops and compares.
module tb_cell_plotter;
  import spy_draw_pkg::*;

  localparam int unsigned CW = 8;
  localparam int unsigned CH = 7;
  localparam int unsigned XW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cell_plotter_if #(.COORD_W(XW)) bus ();

  cell_plotter #(.CELL_W(CW), .CELL_H(CH), .COORD_W(XW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int n_plot = 0;
  int p0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Hand-written raster of one cell into the scoreboard.
  task automatic push_job(input int x, input int y, input int c, input bit f);
    bit edge_px;
    bit vis;
    for (int cy = 0; cy < CH; cy++) begin
      for (int cx = 0; cx < CW; cx++) begin
        edge_px = (cx == 0) || (cx == CW - 1) || (cy == 0) || (cy == CH - 1);
        vis = 1'b1;
`ifdef CELL_PLOTTER_CLIP_EN
        vis = ((x + cx) < 160) && ((y + cy) < 120);
`endif
        if ((f || edge_px) && vis)
          sb.push_back('{1'b0, (x + cx) % 256, (y + cy) % 256, c});
      end
    end
    sb.push_back('{1'b1, 0, 0, 0});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle start strobe; afterwards we sit at "cycle 0" of that request.
  task automatic pulse(input int x, input int y, input logic [2:0] c, input bit f, input bit drawn);
    bus.x_in      = 8'(x);
    bus.y_in      = 8'(y);
    bus.colour_in = c;
    bus.draw_full = f;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (drawn) push_job(x, y, int'(c), f);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!bus.ready && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_timeout", 32'(k < 400), 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.plot) begin
        n_plot++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_plot: got (%0d,%0d), required no plot", bus.vga_x, bus.vga_y);
        end else begin
          e = sb.pop_front();
          if (e.is_done || bus.vga_x !== 8'(e.x) || bus.vga_y !== 8'(e.y) ||
              bus.vga_colour !== 3'(e.c)) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,c%0d), required %s(%0d,%0d,c%0d)",
                     bus.vga_x, bus.vga_y, bus.vga_colour, e.is_done ? "done " : "",
                     e.x, e.y, e.c);
          end
        end
      end
      if (bus.done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done, required nothing pending");
        end else begin
          e = sb.pop_front();
          if (!e.is_done) begin
            errors++;
            $display("FAIL done_early: got done, required pixel (%0d,%0d)", e.x, e.y);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.colour_in = '0;
    bus.draw_full = 1'b0;
    wait_cycles(2);
    chk("rst_ready", 32'(bus.ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_plot", 32'(bus.plot), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_vga_x", 32'(bus.vga_x), 0);
    chk("rst_vga_y", 32'(bus.vga_y), 0);
    chk("rst_colour", 32'(bus.vga_colour), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    reset = 1'b1;
    wait_cycles(2);

    // Filled cell
    p0 = n_plot;
    pulse(28, 30, COL_RED, 1'b1, 1'b1);
    chk("fill_busy_c0", 32'(bus.busy), 1);
    chk("fill_ready_c0", 32'(bus.ready), 0);
    wait_cycles(1);
    chk("fill_first_plot", 32'(bus.plot), 1);
    chk("fill_first_x", 32'(bus.vga_x), 28);
    chk("fill_first_y", 32'(bus.vga_y), 30);
    wait_cycles(55);
    chk("fill_last_x", 32'(bus.vga_x), 35);
    chk("fill_last_y", 32'(bus.vga_y), 36);
    chk("fill_done_c56", 32'(bus.done), 0);
    wait_cycles(1);
    chk("fill_done_c57", 32'(bus.done), 1);
    chk("fill_plot_c57", 32'(bus.plot), 0);
    wait_cycles(1);
    chk("fill_ready_c58", 32'(bus.ready), 1);
    chk("fill_busy_c58", 32'(bus.busy), 0);
    chk("fill_done_c58", 32'(bus.done), 0);
    chk("fill_count", 32'(n_plot - p0), 56);

    // Outline cell
    p0 = n_plot;
    pulse(37, 30, COL_WHITE, 1'b0, 1'b1);
    wait_cycles(10);
    chk("outl_int_x", 32'(bus.vga_x), 38);
    chk("outl_int_y", 32'(bus.vga_y), 31);
    chk("outl_int_plot", 32'(bus.plot), 0);
    wait_cycles(47);
    chk("outl_done_c57", 32'(bus.done), 1);
    wait_cycles(1);
    chk("outl_count", 32'(n_plot - p0), 26);

    // Back-to-back, then overflow
    pulse(10, 50, COL_WHITE, 1'b1, 1'b1);
    wait_cycles(9);
    pulse(60, 50, COL_RED, 1'b0, 1'b1);
    wait_cycles(47);
    chk("b2b_done_c57", 32'(bus.done), 1);
    wait_cycles(1);
    chk("b2b_plot_c58", 32'(bus.plot), 1);
    chk("b2b_x_c58", 32'(bus.vga_x), 60);
    chk("b2b_y_c58", 32'(bus.vga_y), 50);
    chk("b2b_col_c58", 32'(bus.vga_colour), 32'(COL_RED));
    chk("b2b_busy_c58", 32'(bus.busy), 1);
    chk("b2b_overflow", 32'(bus.overflow), 0);
    wait_cycles(1);
    pulse(90, 20, COL_WHITE, 1'b1, 1'b1);
    chk("ovf_pending_ok", 32'(bus.overflow), 0);
    wait_cycles(9);
    pulse(120, 20, COL_RED, 1'b1, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    wait_idle();
    wait_cycles(3);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    chk("ovf_sb_empty", 32'(sb.size()), 0);

    // Reset mid-draw
    pulse(20, 80, COL_RED, 1'b1, 1'b1);
    wait_cycles(20);
    chk("mid_plot_before", 32'(bus.plot), 1);
    reset = 1'b0;
    #1;
    chk("mid_plot_rst", 32'(bus.plot), 0);
    chk("mid_busy_rst", 32'(bus.busy), 0);
    chk("mid_ready_rst", 32'(bus.ready), 1);
    chk("mid_ovf_rst", 32'(bus.overflow), 0);
    sb.delete();
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    chk("mid_ready_after", 32'(bus.ready), 1);
    chk("mid_plot_after", 32'(bus.plot), 0);
    p0 = n_plot;
    pulse(20, 80, COL_RED, 1'b1, 1'b1);
    wait_cycles(1);
    chk("mid_fresh_x", 32'(bus.vga_x), 20);
    chk("mid_fresh_y", 32'(bus.vga_y), 80);
    wait_idle();
    wait_cycles(1);
    chk("mid_fresh_count", 32'(n_plot - p0), 56);

    // Wrap / clip
    p0 = n_plot;
    pulse(252, 10, COL_WHITE, 1'b1, 1'b1);
    wait_cycles(5);
    chk("wrap_x_c5", 32'(bus.vga_x), 0);
`ifdef CELL_PLOTTER_CLIP_EN
    chk("wrap_plot_c5", 32'(bus.plot), 0);
`else
    chk("wrap_plot_c5", 32'(bus.plot), 1);
`endif
    wait_idle();
    wait_cycles(1);
`ifdef CELL_PLOTTER_CLIP_EN
    chk("wrap_count", 32'(n_plot - p0), 0);
`else
    chk("wrap_count", 32'(n_plot - p0), 56);
`endif
    p0 = n_plot;
    pulse(156, 10, COL_RED, 1'b1, 1'b1);
    wait_idle();
    wait_cycles(1);
`ifdef CELL_PLOTTER_CLIP_EN
    chk("clip_count", 32'(n_plot - p0), 28);
`else
    chk("clip_count", 32'(n_plot - p0), 56);
`endif

    wait_cycles(2);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
